// File: rtl/irq_priority_ctrl_pkg.sv
// Shared definitions for the interrupt priority controller and its users.
// Provides the irq_id width derivation and the UART source index map.
package irq_priority_ctrl_pkg;

  localparam int SRC_LSR  = 0;
  localparam int SRC_RDR  = 1;
  localparam int SRC_TMO  = 2;
  localparam int SRC_THRE = 3;
  localparam int SRC_MSR  = 4;

  // Width of an index into n sources; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_priority_ctrl_prio_enc.sv
// Combinational lowest-index-first priority encoder.
// Index 0 has the highest priority; idx is 0 when no request is set.
module irq_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_priority_ctrl.sv
// Parametrised interrupt controller: level/edge sources, sticky edge
// pending latches, per-source enable, fixed priority, registered irq/irq_id.
// Optional macro IRQ_HOLDOFF_EN: suppress irq for HOLDOFF_CYC cycles after
// every valid ack; without it HOLDOFF_CYC is unused.
module irq_priority_ctrl
  import irq_priority_ctrl_pkg::*;
#(
  parameter int                 NUM_SRC     = 4,
  parameter int                 ID_W        = id_width(NUM_SRC),
  parameter logic [NUM_SRC-1:0] EDGE_MASK   = NUM_SRC'(4'b1000),
  parameter int                 HOLDOFF_CYC = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src,
  input  logic [NUM_SRC-1:0] int_en,
  input  logic               ack,
  input  logic [ID_W-1:0]    ack_id,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] pending
);

  logic [NUM_SRC-1:0] src_d;
  logic [NUM_SRC-1:0] ack_hit;
  logic [NUM_SRC-1:0] active;
  logic               act_valid;
  logic [ID_W-1:0]    act_id;
  logic               hold;

  // One-hot ack decode; ids beyond NUM_SRC-1 decode to nothing.
  always_comb begin
    ack_hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ack_hit[i] = ack && (ack_id == ID_W'(i));
    end
  end

  // Edge history and pending latches; a rise wins over a same-cycle ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_d   <= '0;
      pending <= '0;
    end else begin
      src_d   <= src;
      pending <= (EDGE_MASK & ((src & ~src_d) | (pending & ~ack_hit)))
               | (~EDGE_MASK & src);
    end
  end

  assign active = pending & int_en;

  irq_prio_enc #(
    .N (NUM_SRC),
    .W (ID_W)
  ) u_enc (
    .req   (active),
    .valid (act_valid),
    .idx   (act_id)
  );

`ifdef IRQ_HOLDOFF_EN
  localparam int CNT_W = $clog2(HOLDOFF_CYC + 1);

  logic             valid_ack;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  assign valid_ack = |ack_hit;

  // Next holdoff count: reload on any valid ack, otherwise count down to 0.
  always_comb begin
    cnt_next = cnt;
    if (valid_ack) begin
      cnt_next = CNT_W'(HOLDOFF_CYC);
    end else if (cnt != '0) begin
      cnt_next = cnt - CNT_W'(1);
    end
  end

  // Holdoff down-counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  assign hold = (cnt_next != '0);
`else
  assign hold = 1'b0;
`endif

  // Registered request and winner id; id freezes while irq is held off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq    <= 1'b0;
      irq_id <= '0;
    end else begin
      irq <= act_valid & ~hold;
      if (!hold) begin
        irq_id <= act_id;
      end
    end
  end

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Self-checking bench for irq_priority_ctrl (NUM_SRC=4, source 3 edge type).
module tb_irq_priority_ctrl;

  localparam int NUM_SRC = 4;
  localparam int HOLD    = 8;
  localparam logic [3:0] EDGES = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] src;
  logic [3:0] int_en;
  logic       ack;
  logic [1:0] ack_id;
  logic       irq;
  logic [1:0] irq_id;
  logic [3:0] pending;

  int n_checks = 0;
  int n_fail   = 0;

  irq_priority_ctrl #(
    .NUM_SRC     (NUM_SRC),
    .ID_W        (2),
    .EDGE_MASK   (EDGES),
    .HOLDOFF_CYC (HOLD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .src     (src),
    .int_en  (int_en),
    .ack     (ack),
    .ack_id  (ack_id),
    .irq     (irq),
    .irq_id  (irq_id),
    .pending (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: rules applied to the inputs seen at each rising edge.
  bit [3:0] m_pend, m_srcd;
  bit       m_irq;
  int       m_id, m_cnt, m_win;
  bit       m_hold;

  always @(posedge clk) begin
    if (rst_n !== 1'b1) begin
      m_pend = '0; m_srcd = '0; m_irq = 0; m_id = 0; m_cnt = 0;
    end else begin
      m_win = -1;
      for (int i = 0; i < NUM_SRC; i++)
        if (m_win < 0 && m_pend[i] && int_en[i]) m_win = i;
      m_hold = 0;
`ifdef IRQ_HOLDOFF_EN
      if (ack && int'(ack_id) < NUM_SRC) m_cnt = HOLD;
      else if (m_cnt > 0) m_cnt = m_cnt - 1;
      m_hold = (m_cnt > 0);
`endif
      m_irq = (m_win >= 0) && !m_hold;
      if (!m_hold) m_id = (m_win >= 0) ? m_win : 0;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (EDGES[i]) begin
          if (src[i] && !m_srcd[i]) m_pend[i] = 1;
          else if (ack && int'(ack_id) == i) m_pend[i] = 0;
        end else begin
          m_pend[i] = src[i];
        end
      end
      m_srcd = src;
    end
  end

  // Cycle compare, 1 time unit after every rising edge.
  always @(posedge clk) begin
    #1;
    chk("model_irq", int'(irq), int'(m_irq));
    chk("model_irq_id", int'(irq_id), m_id);
    chk("model_pending", int'(pending), int'(m_pend));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Extra settling after an ack so holdoff builds see irq recover.
  task automatic after_ack();
`ifdef IRQ_HOLDOFF_EN
    cyc(HOLD + 2);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int lowcnt;
    rst_n = 0; src = 4'b1111; int_en = 4'b1111; ack = 0; ack_id = 0;

    // 1: reset with all sources high
    cyc(3);
    chk("rst_irq", int'(irq), 0);
    chk("rst_id", int'(irq_id), 0);
    chk("rst_pending", int'(pending), 0);
    rst_n = 1;
    cyc(1);
    chk("rel_pending", int'(pending), 15);
    chk("rel_irq_lat", int'(irq), 0);
    cyc(1);
    chk("rel_irq", int'(irq), 1);
    chk("rel_id", int'(irq_id), 0);

    // 2: level sources, clearing sticky bit 3 on the way
    src = 4'b0110; int_en = 4'b0111; ack = 1; ack_id = 3;
    cyc(1);
    ack = 0;
    chk("l_pend", int'(pending), 6);
    after_ack();
    cyc(1);
    chk("l_irq", int'(irq), 1);
    chk("l_id1", int'(irq_id), 1);
    src = 4'b0100;
    cyc(1);
    chk("l_id_lat", int'(irq_id), 1);
    cyc(1);
    chk("l_id2", int'(irq_id), 2);
    chk("l_irq_hi", int'(irq), 1);
    src = 4'b0000;
    cyc(2);
    chk("l_irq_off", int'(irq), 0);
    chk("l_id_off", int'(irq_id), 0);

    // 3: edge source pulse, ack, repeat ack
    int_en = 4'b1000; src = 4'b1000;
    cyc(1);
    src = 4'b0000;
    cyc(1);
    chk("e_pend", int'(pending), 8);
    chk("e_irq", int'(irq), 1);
    chk("e_id", int'(irq_id), 3);
    cyc(3);
    chk("e_sticky", int'(irq), 1);
    ack = 1; ack_id = 3;
    cyc(1);
    ack = 0;
    chk("e_pend_clr", int'(pending), 0);
    cyc(1);
    chk("e_irq_clr", int'(irq), 0);
    ack = 1;
    cyc(1);
    ack = 0;
    cyc(2);
    chk("e_reack_irq", int'(irq), 0);
    chk("e_reack_pend", int'(pending), 0);
    after_ack();

    // 4: rise coincident with ack, set wins
    src = 4'b1000;
    cyc(1);
    src = 4'b0000;
    cyc(2);
    src = 4'b1000; ack = 1; ack_id = 3;
    cyc(1);
    src = 4'b0000; ack = 0;
    chk("sw_pend", int'(pending), 8);
    cyc(1);
`ifndef IRQ_HOLDOFF_EN
    chk("sw_irq", int'(irq), 1);
`endif
    after_ack();
    cyc(2);
    chk("sw_irq_late", int'(irq), 1);

    // 5: masked pending, re-enable, ignored ack of a non-pending source
    int_en = 4'b0000;
    cyc(1);
    chk("m_irq_off", int'(irq), 0);
    chk("m_pend_kept", int'(pending), 8);
    int_en = 4'b1000;
    cyc(1);
    chk("m_irq_on", int'(irq), 1);
    ack = 1; ack_id = 1;
    cyc(1);
    ack = 0;
    after_ack();
    cyc(2);
    chk("m_ign_pend", int'(pending), 8);
    chk("m_ign_irq", int'(irq), 1);
    chk("m_ign_id", int'(irq_id), 3);

    // priority pre-emption with irq held high
    int_en = 4'b1111; src = 4'b0100;
    cyc(2);
    chk("p_id2", int'(irq_id), 2);
    src = 4'b0101;
    cyc(1);
    chk("p_hi_a", int'(irq), 1);
    cyc(1);
    chk("p_id0", int'(irq_id), 0);
    chk("p_hi_b", int'(irq), 1);

`ifdef IRQ_HOLDOFF_EN
    // 6: holdoff length, single and reloaded
    ack = 1; ack_id = 3;
    cyc(1);
    ack = 0;
    src = 4'b0010; int_en = 4'b0010;
    cyc(HOLD + 4);
    for (int pass = 0; pass < 2; pass++) begin
      lowcnt = 0;
      for (int k = 0; k < 40; k++) begin
        ack = (k == 0) || (pass == 1 && k == 4);
        ack_id = 1;
        cyc(1);
        if (irq == 1'b0) lowcnt++;
      end
      ack = 0;
      chk(pass == 0 ? "h_len8" : "h_len12", lowcnt, pass == 0 ? 8 : 12);
    end
`endif

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
